ps2_key_sequencer: RTL

Consumes the byte stream from the PS/2 receiver (`scancode` plus one-cycle `new_code` strobe) and turns scan-code set 2 sequences into discrete key events. Prefix bytes are handled by a state machine: `E0` extended, `F0` break, and `E1` Pause. The block tracks Shift modifier state, filters keyboard control responses, and buffers events in a small FIFO with a valid/ready handshake toward the game/display logic.

---
 rtl/ps2_key_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 scan-code sequencer: folds E0/F0/E1 prefixes into key events, tracks Shift, buffers events in a FIFO.
// Optional build macro PS2_SEQ_TIMEOUT_EN abandons partial sequences after TIMEOUT_CYCLES idle clocks.
module ps2_key_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scancode,
    input  logic       new_code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic       shift_held,
    output logic       overflow,
    output logic       seq_abort
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EW = 10;

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_PAUSE} state_e;

    state_e          state_q, state_d;
    logic [2:0]      pause_q, pause_d;
    logic            lshift_q, lshift_d, rshift_q, rshift_d;
    logic            ovf_q, ovf_d, abort_q, abort_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            emit_c, emit_brk_c, emit_ext_c, timeout_hit_c;
    logic [7:0]      emit_code_c;
    logic            full_c, pop_c, push_ok_c;

`ifdef PS2_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q, to_d;

    // Stall counter: runs only while a sequence is partial and no byte arrives.
    always_comb begin
        to_d          = '0;
        timeout_hit_c = 1'b0;
        if (state_q != S_IDLE && !new_code) begin
            if (to_q == TW'(TIMEOUT_CYCLES)) timeout_hit_c = 1'b1;
            else                             to_d = to_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_q <= '0;
        else        to_q <= to_d;
    end
`else
    assign timeout_hit_c = 1'b0;
`endif

    // Prefix decode and event emission.
    always_comb begin
        state_d     = state_q;
        pause_d     = pause_q;
        emit_c      = 1'b0;
        emit_code_c = scancode;
        emit_brk_c  = 1'b0;
        emit_ext_c  = 1'b0;
        abort_d     = 1'b0;
        if (new_code) begin
            unique case (state_q)
                S_IDLE: begin
                    unique case (scancode)
                        8'hE0: state_d = S_EXT;
                        8'hF0: state_d = S_BRK;
                        8'hE1: begin
                            state_d = S_PAUSE;
                            pause_d = 3'd0;
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        default: emit_c = 1'b1;
                    endcase
                end
                S_EXT: begin
                    if (scancode == 8'hF0) begin
                        state_d = S_EXTBRK;
                    end else if (scancode != 8'hE0) begin
                        emit_c     = 1'b1;
                        emit_ext_c = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                S_BRK: begin
                    emit_c     = 1'b1;
                    emit_brk_c = 1'b1;
                    state_d    = S_IDLE;
                end
                S_EXTBRK: begin
                    emit_c     = 1'b1;
                    emit_brk_c = 1'b1;
                    emit_ext_c = 1'b1;
                    state_d    = S_IDLE;
                end
                S_PAUSE: begin
                    if (pause_q == 3'd6) begin
                        emit_c      = 1'b1;
                        emit_code_c = 8'hE1;
                        pause_d     = 3'd0;
                        state_d     = S_IDLE;
                    end else begin
                        pause_d = pause_q + 3'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timeout_hit_c) begin
            state_d = S_IDLE;
            pause_d = 3'd0;
            abort_d = 1'b1;
        end
    end

    // Shift tracking follows emitted events even when the FIFO drops them.
    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        if (emit_c && !emit_ext_c && emit_code_c == 8'h12) lshift_d = !emit_brk_c;
        if (emit_c && !emit_ext_c && emit_code_c == 8'h59) rshift_d = !emit_brk_c;
    end

    assign full_c    = (count_q == CW'(FIFO_DEPTH));
    assign pop_c     = evt_valid && evt_ready;
    assign push_ok_c = emit_c && (!full_c || pop_c);
    assign ovf_d     = emit_c && full_c && !pop_c;

    always_comb begin
        count_d = count_q;
        if (push_ok_c && !pop_c)      count_d = count_q + CW'(1);
        else if (!push_ok_c && pop_c) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pause_q  <= 3'd0;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            ovf_q    <= 1'b0;
            abort_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pause_q  <= pause_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            ovf_q    <= ovf_d;
            abort_q  <= abort_d;
            count_q  <= count_d;
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= {emit_code_c, emit_brk_c, emit_ext_c};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign evt_valid  = (count_q != '0);
    assign evt_code   = evt_valid ? mem_q[rd_ptr_q][9:2] : 8'h00;
    assign evt_break  = evt_valid ? mem_q[rd_ptr_q][1]   : 1'b0;
    assign evt_ext    = evt_valid ? mem_q[rd_ptr_q][0]   : 1'b0;
    assign shift_held = lshift_q | rshift_q;
    assign overflow   = ovf_q;
    assign seq_abort  = abort_q;
endmodule
